// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: condition evaluation, target/fall-through PC, mispredict flag and count.
// Optional 2-bit branch history table, enabled by defining BRU_BHT_EN.
module branch_resolve_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  rdata1,
    input  logic [XLEN-1:0]  rdata2,
    input  logic [2:0]       br_type,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_next_pc,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [CNT_W-1:0] mispredict_cnt,
    input  logic [XLEN-1:0]  query_pc,
    output logic             query_taken
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic            accept;
    logic            out_fire;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            legal;
    logic            taken_c;
    logic            mispredict_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] seq_pc_c;
    logic [XLEN-1:0] next_pc_c;

    // Handshakes; flush wins over both sides.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign out_fire = out_valid && out_ready && !flush;

    assign eq   = (rdata1 == rdata2);
    assign lt_s = ($signed(rdata1) < $signed(rdata2));
    assign lt_u = (rdata1 < rdata2);

    // Condition decode on funct3; 010/011 are not branches.
    always_comb begin
        legal   = 1'b1;
        taken_c = 1'b0;
        case (br_type)
            3'b000:  taken_c = eq;
            3'b001:  taken_c = !eq;
            3'b100:  taken_c = lt_s;
            3'b101:  taken_c = !lt_s;
            3'b110:  taken_c = lt_u;
            3'b111:  taken_c = !lt_u;
            default: legal   = 1'b0;
        endcase
    end

    assign target_c     = in_pc + in_imm;
    assign seq_pc_c     = in_pc + XLEN'(4);
    assign next_pc_c    = taken_c ? target_c : seq_pc_c;
    assign mispredict_c = legal && (taken_c != in_pred_taken);

    // Output register and misprediction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_target     <= '0;
            out_next_pc    <= '0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                out_taken      <= taken_c;
                out_target     <= target_c;
                out_next_pc    <= next_pc_c;
                out_mispredict <= mispredict_c;
                out_illegal    <= !legal;
            end

            if (out_fire && out_mispredict && (mispredict_cnt != {CNT_W{1'b1}})) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end

    logic unused_query;
    assign unused_query = ^query_pc;

`ifdef BRU_BHT_EN
    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] qry_idx;

    assign upd_idx = in_pc[IDX_W+1:2];
    assign qry_idx = query_pc[IDX_W+1:2];

    // 2-bit saturating counters trained by every accepted legal branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accept && legal) begin
            if (taken_c) begin
                if (bht[upd_idx] != 2'b11) begin
                    bht[upd_idx] <= bht[upd_idx] + 2'd1;
                end
            end else if (bht[upd_idx] != 2'b00) begin
                bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end

    // Reads the stored value; a same-cycle update is visible only next cycle.
    assign query_taken = bht[qry_idx][1];
`else
    logic [IDX_W-1:0] unused_bht_idx;
    assign unused_bht_idx = query_pc[IDX_W+1:2];
    assign query_taken    = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table plus scoreboard, with stall/flush/reset/BHT sequences.
module tb_branch_resolve_unit;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned BHT_DEPTH = 64;
    localparam int unsigned CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_imm;
    logic [XLEN-1:0]  rdata1;
    logic [XLEN-1:0]  rdata2;
    logic [2:0]       br_type;
    logic             in_pred_taken;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [XLEN-1:0]  out_target;
    logic [XLEN-1:0]  out_next_pc;
    logic             out_mispredict;
    logic             out_illegal;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [XLEN-1:0]  query_pc;
    logic             query_taken;

    branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .rdata1(rdata1), .rdata2(rdata2),
        .br_type(br_type), .in_pred_taken(in_pred_taken),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target), .out_next_pc(out_next_pc),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal),
        .mispredict_cnt(mispredict_cnt),
        .query_pc(query_pc), .query_taken(query_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [2:0]  bt;
        logic        pred;
        logic        taken;
        logic        mis;
        logic        ill;
    } vec_t;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [31:0] next_pc;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t             exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] cnt_m;
    logic [1:0]       bht_m [BHT_DEPTH];
    vec_t             tbl [16];
    vec_t             idle_v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cnt_m = '0;
        for (int i = 0; i < int'(BHT_DEPTH); i++) bht_m[i] = 2'b01;
    endtask

    // One cycle: drive, check current outputs against the scoreboard head, update model, clock.
    task automatic tick(input vec_t v, input logic vld, input logic ordy, input logic fl);
        exp_t e;
        exp_t h;
        logic exp_ready;
        logic [5:0] idx;
        in_pc = v.pc; in_imm = v.imm; rdata1 = v.r1; rdata2 = v.r2;
        br_type = v.bt; in_pred_taken = v.pred;
        in_valid = vld; out_ready = ordy; flush = fl;
        #1;
        exp_ready = (exp_q.size() == 0) || ordy;
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("mispredict_cnt", 64'(mispredict_cnt), 64'(cnt_m));
`ifdef BRU_BHT_EN
        check("query_taken", 64'(query_taken), 64'(bht_m[query_pc[7:2]][1]));
`else
        check("query_taken", 64'(query_taken), 64'(1'b0));
`endif
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check("out_taken", 64'(out_taken), 64'(h.taken));
            check("out_target", 64'(out_target), 64'(h.target));
            check("out_next_pc", 64'(out_next_pc), 64'(h.next_pc));
            check("out_mispredict", 64'(out_mispredict), 64'(h.mis));
            check("out_illegal", 64'(out_illegal), 64'(h.ill));
            if (fl) begin
                void'(exp_q.pop_front());
            end else if (ordy) begin
                void'(exp_q.pop_front());
                if (h.mis && (cnt_m != {CNT_W{1'b1}})) cnt_m = cnt_m + 1'b1;
            end
        end
        if (vld && exp_ready && !fl) begin
            e.taken   = v.taken;
            e.target  = v.pc + v.imm;
            e.next_pc = v.taken ? (v.pc + v.imm) : (v.pc + 32'd4);
            e.mis     = v.mis;
            e.ill     = v.ill;
            exp_q.push_back(e);
            if (!v.ill) begin
                idx = v.pc[7:2];
                if (v.taken && bht_m[idx] != 2'b11) bht_m[idx] = bht_m[idx] + 2'd1;
                else if (!v.taken && bht_m[idx] != 2'b00) bht_m[idx] = bht_m[idx] - 2'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic vld);
        rst_n = 1'b0; in_valid = vld; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'(1'b0));
        check("rst out_taken", 64'(out_taken), 64'(1'b0));
        check("rst out_target", 64'(out_target), 64'(0));
        check("rst out_next_pc", 64'(out_next_pc), 64'(0));
        check("rst out_mispredict", 64'(out_mispredict), 64'(1'b0));
        check("rst out_illegal", 64'(out_illegal), 64'(1'b0));
        check("rst mispredict_cnt", 64'(mispredict_cnt), 64'(0));
        check("rst in_ready", 64'(in_ready), 64'(1'b1));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // pc, imm, r1, r2, br_type, pred, exp taken, exp mispredict, exp illegal
        tbl[0]  = '{32'h0000_1000, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{32'h0000_1004, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{32'h0000_1008, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{32'h0000_100C, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0005, 32'h0000_0005, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{32'h0000_2000, 32'h0000_0100, 32'h0000_0007, 32'h0000_0007, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{32'h0000_2004, 32'h0000_0100, 32'h0000_0001, 32'h0000_0002, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{32'h0000_3000, 32'h0000_0010, 32'h1234_5678, 32'h1234_5678, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{32'h0000_3004, 32'h0000_0010, 32'h1234_5678, 32'h1234_5679, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{32'h0000_3008, 32'h0000_0010, 32'h8000_0000, 32'h0000_0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{32'h0000_4000, 32'h0000_0020, 32'h7FFF_FFFF, 32'h8000_0000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{32'h0000_4004, 32'h0000_0020, 32'h7FFF_FFFF, 32'h8000_0000, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{32'h0000_4008, 32'h0000_0020, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{32'h0000_400C, 32'h0000_0020, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{32'h0000_4010, 32'h0000_0020, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{32'h0000_0100, 32'hFFFF_FFF0, 32'h8000_0001, 32'h0000_0001, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0};
        idle_v  = '{32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; query_pc = '0;
        in_pc = '0; in_imm = '0; rdata1 = '0; rdata2 = '0; br_type = '0; in_pred_taken = 1'b0;
        @(negedge clk);
        do_reset(1'b0);

        // Back-to-back table, one branch per cycle, querying the branch's own PC.
        for (int i = 0; i < 16; i++) begin
            query_pc = tbl[i].pc;
            tick(tbl[i], 1'b1, 1'b1, 1'b0);
        end
        tick(idle_v, 1'b0, 1'b1, 1'b0);
        tick(idle_v, 1'b0, 1'b1, 1'b0);

        // Output stall for three cycles with a branch waiting, then release.
        tick(tbl[0], 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(tbl[1], 1'b1, 1'b0, 1'b0);
        tick(tbl[1], 1'b1, 1'b1, 1'b0);
        tick(tbl[2], 1'b1, 1'b1, 1'b0);
        tick(idle_v, 1'b0, 1'b1, 1'b0);
        tick(idle_v, 1'b0, 1'b1, 1'b0);

        // Flush drops a held mispredicting result and the branch offered alongside it.
        tick(tbl[4], 1'b1, 1'b1, 1'b0);
        tick(tbl[8], 1'b1, 1'b1, 1'b1);
        tick(idle_v, 1'b0, 1'b1, 1'b0);
        tick(idle_v, 1'b0, 1'b1, 1'b0);

        // Reset with a stalled result held and input still offered.
        tick(tbl[2], 1'b1, 1'b0, 1'b0);
        tick(tbl[3], 1'b1, 1'b0, 1'b0);
        do_reset(1'b1);
        tick(idle_v, 1'b0, 1'b1, 1'b0);

        // Three taken branches at 0x100, each querying 0x100 in the same cycle.
        query_pc = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            tick('{32'h0000_0100, 32'h0000_0040, 32'h0000_0003, 32'h0000_0003, 3'b000, 1'b1,
                   1'b1, 1'b0, 1'b0}, 1'b1, 1'b1, 1'b0);
        end
        tick(idle_v, 1'b0, 1'b1, 1'b0);
        tick(idle_v, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
